pid_controller_mc: RTL and testbench
====================================

Name: pid_controller_mc

Overview:
Multi-channel, time-multiplexed PID controller; successor to the single-channel controller.
- Serves NUM_CH independent loops, e.g. left and right wall distance, from one shared multiplier sequenced by an FSM.
- Adds per-channel gains, integrator clamping (anti-windup), output saturation with flag, integrator clear, and an external sample strobe.
- Sits between the sensor front-end (setpoint/feedback) and the motor PWM stage; sample_tick comes from the existing clk_enable divider.

Parameters:
NUM_CH, 2, number of independent PID channels (1..8)
PID_INT_WIDTH, 8, integer bits of unsigned gains
PID_FRAC_WIDTH, 8, fractional bits of gains and internal accumulators
SP_WIDTH, 9, unsigned setpoint/feedback width
PID_OUT_WIDTH, 16, signed integer output width
INT_LIMIT, 1000, integrator clamp magnitude, in integer (output) units

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_tick  in  1  one-cycle strobe that starts a sweep of all channels
k_p  in  NUM_CH x (PID_INT_WIDTH+PID_FRAC_WIDTH)  per-channel unsigned Q gain
k_i  in  NUM_CH x (PID_INT_WIDTH+PID_FRAC_WIDTH)  per-channel unsigned Q gain
k_d  in  NUM_CH x (PID_INT_WIDTH+PID_FRAC_WIDTH)  per-channel unsigned Q gain
setpoint  in  NUM_CH x SP_WIDTH  target per channel
feedback  in  NUM_CH x SP_WIDTH  measured value per channel
int_clear  in  NUM_CH  per-channel integrator/prev-error clear, level
control_out  out  NUM_CH x PID_OUT_WIDTH  signed saturated control per channel
sat  out  NUM_CH  channel output saturated on last update
out_valid  out  1  one-cycle pulse: all outputs updated
busy  out  1  sweep in progress
overrun  out  1  sticky: sample_tick arrived while busy

Behaviour:
- Reset (asynchronous): all outputs 0, all integrators 0, prev_error 0, FSM in IDLE.
- FSM states: IDLE -> ERR -> P -> I -> D -> SUM, then next channel's ERR or back to IDLE.
  - IDLE -> ERR on sample_tick, with channel index 0.
  - ERR: latch e = setpoint - feedback. Signed SP_WIDTH+1 bits, promoted to Q with PID_FRAC_WIDTH zero fraction bits. Operands sampled only in this cycle.
  - P: u_p = k_p*e, with gains zero-extended to signed.
  - I: acc = acc + k_i*e, then clamped to [-INT_LIMIT<<FRAC, +INT_LIMIT<<FRAC].
  - D: u_d = k_d*(e - prev_e); then prev_e <= e.
  - SUM: s = u_p + acc + u_d, carried at full width with no intermediate wrap.
    - out = s >>> PID_FRAC_WIDTH, arithmetic shift, floor.
    - Saturate out to [-2^(W-1), 2^(W-1)-1]; sat[ch] = 1 if clamped, else 0.
    - Write control_out[ch]. If ch = NUM_CH-1, go to IDLE; else ch+1 and go to ERR.
- out_valid pulses in the first IDLE cycle after the last SUM.
  - Latency sample_tick -> out_valid = 5*NUM_CH + 1 cycles (11 at default).
  - Channels update individually, and out_valid marks that the set is coherent.
- busy = 1 from the cycle after sample_tick until out_valid, inclusive of the last SUM.
- sample_tick while busy is ignored and sets overrun, which clears only on reset. sample_tick in the same cycle as out_valid is accepted.
- int_clear[ch] high: when that channel's I and D states execute, acc and prev_e load 0 instead of updating. P still computes, so output = proportional term only.
- First sample after reset: prev_e = 0, so the derivative sees the full error step. This is intended.
- Reset mid-sweep aborts the sweep. The partially written outputs are forced to 0 and no out_valid is issued.
- Gains and inputs may change at any time; only ERR-cycle and current-state values are used.

Decomposition:
- Package pid_pkg:
  - state enum pid_state_t (IDLE, ERR, P, I, D, SUM)
  - width localparams: ERR_W, PROD_W, ACC_W, SUM_W
  - function sat_trunc (shift + saturate)
- Sub-module pid_mac: one signed multiplier with registered output, used for P/I/D. All other logic lives in the top-level FSM/datapath.
- Per-channel acc/prev_e are register arrays indexed by the channel counter.

Test Plan:
1. Ch0 k_p=0x0100 (1.0), k_i=k_d=0, sp=300, fb=100, one tick -> control_out[0]=200, sat=0, out_valid exactly 11 cycles after tick.
2. Ch1 k_p=0xFF00, sp=511, fb=0 -> product 130305 saturates: control_out[1]=32767, sat[1]=1. Swap sp/fb -> -32768, sat=1.
3. Integrator: k_i=0x0080 (0.5), error 10, 4 ticks -> outputs 5,10,15,20. Then k_i=0xFF00, error 511 -> acc clamps, output held at 1000 on every subsequent tick.
4. Derivative: k_d=0x0200 (2.0), error 0 then step to 50 -> outputs 0, 100, 0. Assert int_clear during the step -> output 0 and acc/prev_e read 0.
5. Overrun/back-to-back: tick, second tick 4 cycles later -> second ignored, overrun=1, single out_valid. Tick on the out_valid cycle -> new sweep starts.
6. Reset asserted during channel 1 SUM -> all outputs 0, busy=0, no out_valid; next tick produces correct values with prev_e=0.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared types, datapath widths and output shift/saturate helper for pid_controller_mc.
// Widths mirror the controller's default parameter set.
package pid_pkg;

  localparam int SP_W   = 9;
  localparam int GAIN_W = 16;
  localparam int FRAC_W = 8;
  localparam int OUT_W  = 16;

  localparam int ERR_W  = SP_W + 1;
  localparam int DIFF_W = ERR_W + 1;
  localparam int PROD_W = DIFF_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + 1;
  localparam int SUM_W  = PROD_W + 3;

  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(64'sd1 <<< (OUT_W - 1)));

  typedef enum logic [2:0] {IDLE, ERR, P, I, D, SUM} pid_state_t;

  typedef struct packed {
    logic [OUT_W-1:0] val;
    logic             sat;
  } sat_res_t;

  // Floor-shift the Q sum back to integer units, then clamp to the output range.
  function automatic sat_res_t sat_trunc(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] sh;
    sat_res_t                r;
    sh = s >>> FRAC_W;
    if (sh > OUT_MAX) begin
      r.val = OUT_MAX[OUT_W-1:0];
      r.sat = 1'b1;
    end else if (sh < OUT_MIN) begin
      r.val = OUT_MIN[OUT_W-1:0];
      r.sat = 1'b1;
    end else begin
      r.val = sh[OUT_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pid_controller_mc_mac.sv
// Shared signed multiplier with registered product; the gain operand is unsigned Q.
module pid_mac
  import pid_pkg::*;
(
  input  logic                     clk,
  input  logic signed [DIFF_W-1:0] a,
  input  logic        [GAIN_W-1:0] gain,
  output logic signed [PROD_W-1:0] prod
);

  logic signed [PROD_W-1:0] ax;
  logic signed [PROD_W-1:0] bx;

  assign ax = PROD_W'(a);
  assign bx = $signed({{(PROD_W - GAIN_W){1'b0}}, gain});

  always_ff @(posedge clk) begin
    prod <= ax * bx;
  end

endmodule

// File: rtl/pid_controller_mc.sv
// Time-multiplexed multi-channel PID: one shared multiplier sequenced per channel
// through ERR/P/I/D/SUM, with integrator clamp, output saturation and overrun flag.
module pid_controller_mc
  import pid_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int PID_INT_WIDTH  = 8,
  parameter int PID_FRAC_WIDTH = 8,
  parameter int SP_WIDTH       = 9,
  parameter int PID_OUT_WIDTH  = 16,
  parameter int INT_LIMIT      = 1000
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   sample_tick,
  input  logic [NUM_CH-1:0][PID_INT_WIDTH+PID_FRAC_WIDTH-1:0]    k_p,
  input  logic [NUM_CH-1:0][PID_INT_WIDTH+PID_FRAC_WIDTH-1:0]    k_i,
  input  logic [NUM_CH-1:0][PID_INT_WIDTH+PID_FRAC_WIDTH-1:0]    k_d,
  input  logic [NUM_CH-1:0][SP_WIDTH-1:0]                        setpoint,
  input  logic [NUM_CH-1:0][SP_WIDTH-1:0]                        feedback,
  input  logic [NUM_CH-1:0]                                      int_clear,
  output logic [NUM_CH-1:0][PID_OUT_WIDTH-1:0]                   control_out,
  output logic [NUM_CH-1:0]                                      sat,
  output logic                                                   out_valid,
  output logic                                                   busy,
  output logic                                                   overrun
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic signed [ACC_W:0] ACC_LIM = (ACC_W + 1)'(INT_LIMIT * (2 ** PID_FRAC_WIDTH));

  pid_state_t               state;
  logic [CH_W-1:0]          ch;
  logic signed [ERR_W-1:0]  e_p;
  logic signed [PROD_W-1:0] up_p;
  logic                     clr_p;
  logic signed [ACC_W-1:0]  acc    [NUM_CH];
  logic signed [ERR_W-1:0]  prev_e [NUM_CH];

  logic signed [DIFF_W-1:0] mac_a;
  logic [GAIN_W-1:0]        mac_gain;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    acc_sum;
  logic signed [ACC_W:0]    acc_clamp;
  logic signed [PROD_W-1:0] d_term;
  logic signed [SUM_W-1:0]  sum_s;
  sat_res_t                 res;

  pid_mac u_mac (
    .clk  (clk),
    .a    (mac_a),
    .gain (mac_gain),
    .prod (prod)
  );

  assign busy = (state != IDLE);

  // The multiplier output lags its operands by one state: u_p lands in I,
  // k_i*e in D, u_d in SUM.
  always_comb begin
    mac_a    = '0;
    mac_gain = '0;
    case (state)
      P: begin
        mac_a    = DIFF_W'(e_p);
        mac_gain = k_p[ch];
      end
      I: begin
        mac_a    = DIFF_W'(e_p);
        mac_gain = k_i[ch];
      end
      D: begin
        mac_a    = DIFF_W'(e_p) - DIFF_W'(prev_e[ch]);
        mac_gain = k_d[ch];
      end
      default: ;
    endcase

    acc_sum   = (ACC_W + 1)'(acc[ch]) + (ACC_W + 1)'(prod);
    acc_clamp = acc_sum;
    if (acc_sum > ACC_LIM)
      acc_clamp = ACC_LIM;
    else if (acc_sum < -ACC_LIM)
      acc_clamp = -ACC_LIM;

    d_term = clr_p ? '0 : prod;
    sum_s  = SUM_W'(up_p) + SUM_W'(acc[ch]) + SUM_W'(d_term);
    res    = sat_trunc(sum_s);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ch          <= '0;
      e_p         <= '0;
      up_p        <= '0;
      clr_p       <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        acc[n]    <= '0;
        prev_e[n] <= '0;
      end
      control_out <= '0;
      sat         <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample_tick && (state != IDLE))
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= ERR;
            ch    <= '0;
          end
        end
        ERR: begin
          e_p   <= $signed({1'b0, setpoint[ch]}) - $signed({1'b0, feedback[ch]});
          state <= P;
        end
        P: state <= I;
        I: begin
          up_p  <= prod;
          state <= D;
        end
        D: begin
          clr_p <= int_clear[ch];
          if (int_clear[ch]) begin
            acc[ch]    <= '0;
            prev_e[ch] <= '0;
          end else begin
            acc[ch]    <= acc_clamp[ACC_W-1:0];
            prev_e[ch] <= e_p;
          end
          state <= SUM;
        end
        SUM: begin
          control_out[ch] <= res.val;
          sat[ch]         <= res.sat;
          if (ch == LAST_CH) begin
            state     <= IDLE;
            out_valid <= 1'b1;
          end else begin
            ch    <= ch + 1'b1;
            state <= ERR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_controller_mc.sv
// Directed bench for pid_controller_mc: proportional, saturation, integrator clamp,
// derivative, integrator clear, overrun, back-to-back ticks and mid-sweep reset.
module tb_pid_controller_mc;

  localparam int NCH = 2;

  logic                     clk;
  logic                     rst;
  logic                     sample_tick;
  logic [NCH-1:0][15:0]     k_p;
  logic [NCH-1:0][15:0]     k_i;
  logic [NCH-1:0][15:0]     k_d;
  logic [NCH-1:0][8:0]      setpoint;
  logic [NCH-1:0][8:0]      feedback;
  logic [NCH-1:0]           int_clear;
  logic [NCH-1:0][15:0]     control_out;
  logic [NCH-1:0]           sat;
  logic                     out_valid;
  logic                     busy;
  logic                     overrun;

  int total = 0;
  int bad   = 0;

  pid_controller_mc dut (
    .clk         (clk),
    .reset       (rst),
    .sample_tick (sample_tick),
    .k_p         (k_p),
    .k_i         (k_i),
    .k_d         (k_d),
    .setpoint    (setpoint),
    .feedback    (feedback),
    .int_clear   (int_clear),
    .control_out (control_out),
    .sat         (sat),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse sample_tick for one cycle and return the cycles until out_valid (-1 on timeout).
  task automatic run_sweep(output int lat);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic zero_inputs();
    k_p = '0; k_i = '0; k_d = '0;
    setpoint = '0; feedback = '0; int_clear = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sample_tick = 1'b0;
    zero_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (control_out !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", control_out); end
    total++; if (sat !== 2'b00) begin bad++; $display("FAIL reset_sat got=%b exp=00", sat); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_prop();
    int lat;
    zero_inputs();
    k_p[0] = 16'h0100; setpoint[0] = 9'd300; feedback[0] = 9'd100;
    run_sweep(lat);
    total++; if (lat !== 11) begin bad++; $display("FAIL prop_latency got=%0d exp=11", lat); end
    total++; if (control_out[0] !== 16'd200) begin bad++; $display("FAIL prop_out0 got=%0d exp=200", $signed(control_out[0])); end
    total++; if (sat !== 2'b00) begin bad++; $display("FAIL prop_sat got=%b exp=00", sat); end
    total++; if (control_out[1] !== 16'd0) begin bad++; $display("FAIL prop_out1 got=%0d exp=0", $signed(control_out[1])); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL prop_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_sat();
    int lat;
    zero_inputs();
    k_p[1] = 16'hFF00; setpoint[1] = 9'd511; feedback[1] = 9'd0;
    run_sweep(lat);
    total++; if (control_out[1] !== 16'h7FFF) begin bad++; $display("FAIL sat_pos_out got=%0d exp=32767", $signed(control_out[1])); end
    total++; if (sat !== 2'b10) begin bad++; $display("FAIL sat_pos_flag got=%b exp=10", sat); end
    total++; if (control_out[0] !== 16'd0) begin bad++; $display("FAIL sat_pos_out0 got=%0d exp=0", $signed(control_out[0])); end
    setpoint[1] = 9'd0; feedback[1] = 9'd511;
    run_sweep(lat);
    total++; if (control_out[1] !== 16'h8000) begin bad++; $display("FAIL sat_neg_out got=%0d exp=-32768", $signed(control_out[1])); end
    total++; if (sat !== 2'b10) begin bad++; $display("FAIL sat_neg_flag got=%b exp=10", sat); end
    total++; if (lat !== 11) begin bad++; $display("FAIL sat_latency got=%0d exp=11", lat); end
  endtask

  task automatic test_integ();
    int lat;
    int exp_i [4] = '{5, 10, 15, 20};
    zero_inputs();
    k_i[0] = 16'h0080; setpoint[0] = 9'd110; feedback[0] = 9'd100;
    for (int n = 0; n < 4; n++) begin
      run_sweep(lat);
      total++; if (control_out[0] !== 16'(exp_i[n])) begin bad++; $display("FAIL integ_step%0d got=%0d exp=%0d", n, $signed(control_out[0]), exp_i[n]); end
    end
    k_i[0] = 16'hFF00; setpoint[0] = 9'd511; feedback[0] = 9'd0;
    for (int n = 0; n < 3; n++) begin
      run_sweep(lat);
      total++; if (control_out[0] !== 16'd1000) begin bad++; $display("FAIL integ_clamp%0d got=%0d exp=1000", n, $signed(control_out[0])); end
      total++; if (sat[0] !== 1'b0) begin bad++; $display("FAIL integ_clamp_sat%0d got=%b exp=0", n, sat[0]); end
    end
    int_clear[0] = 1'b1;
    run_sweep(lat);
    total++; if (control_out[0] !== 16'd0) begin bad++; $display("FAIL integ_clear got=%0d exp=0", $signed(control_out[0])); end
    int_clear[0] = 1'b0;
    k_i[0] = 16'h0080; setpoint[0] = 9'd110; feedback[0] = 9'd100;
    run_sweep(lat);
    total++; if (control_out[0] !== 16'd5) begin bad++; $display("FAIL integ_after_clear got=%0d exp=5", $signed(control_out[0])); end
  endtask

  task automatic test_deriv();
    int lat;
    zero_inputs();
    int_clear[0] = 1'b1;
    setpoint[0] = 9'd100; feedback[0] = 9'd100;
    run_sweep(lat);
    int_clear[0] = 1'b0;
    k_d[0] = 16'h0200;
    run_sweep(lat);
    total++; if (control_out[0] !== 16'd0) begin bad++; $display("FAIL deriv_flat got=%0d exp=0", $signed(control_out[0])); end
    setpoint[0] = 9'd150;
    run_sweep(lat);
    total++; if (control_out[0] !== 16'd100) begin bad++; $display("FAIL deriv_step got=%0d exp=100", $signed(control_out[0])); end
    run_sweep(lat);
    total++; if (control_out[0] !== 16'd0) begin bad++; $display("FAIL deriv_hold got=%0d exp=0", $signed(control_out[0])); end
    setpoint[0] = 9'd100;
    run_sweep(lat);
    total++; if (control_out[0] !== 16'hFF9C) begin bad++; $display("FAIL deriv_down got=%0d exp=-100", $signed(control_out[0])); end
    setpoint[0] = 9'd150; int_clear[0] = 1'b1;
    run_sweep(lat);
    total++; if (control_out[0] !== 16'd0) begin bad++; $display("FAIL deriv_clear got=%0d exp=0", $signed(control_out[0])); end
    int_clear[0] = 1'b0;
    run_sweep(lat);
    total++; if (control_out[0] !== 16'd100) begin bad++; $display("FAIL deriv_prev_cleared got=%0d exp=100", $signed(control_out[0])); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int pulses;
    int first;
    zero_inputs();
    k_p[0] = 16'h0100; setpoint[0] = 9'd300; feedback[0] = 9'd100;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_before got=%b exp=0", overrun); end
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovr_busy got=%b exp=1", busy); end
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    pulses = 0; first = -1;
    for (int i = 5; i <= 30; i++) begin
      if (out_valid) begin
        pulses++;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", pulses); end
    total++; if (first !== 11) begin bad++; $display("FAIL ovr_latency got=%0d exp=11", first); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end

    run_sweep(lat);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    total++; if (lat !== 11) begin bad++; $display("FAIL b2b_latency got=%0d exp=11", lat); end
    total++; if (control_out[0] !== 16'd200) begin bad++; $display("FAIL b2b_out0 got=%0d exp=200", $signed(control_out[0])); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses;
    zero_inputs();
    k_p[0] = 16'h0100; setpoint[0] = 9'd300; feedback[0] = 9'd100;
    k_d[1] = 16'h0100; setpoint[1] = 9'd130; feedback[1] = 9'd100;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (9) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
    total++; if (control_out[0] !== 16'd200) begin bad++; $display("FAIL mid_partial got=%0d exp=200", $signed(control_out[0])); end
    rst = 1'b1;
    #1;
    total++; if (control_out !== '0) begin bad++; $display("FAIL mid_rst_out got=%h exp=0", control_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL mid_rst_overrun got=%b exp=0", overrun); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_valid got=%0d exp=0", pulses); end
    run_sweep(lat);
    total++; if (lat !== 11) begin bad++; $display("FAIL mid_after_latency got=%0d exp=11", lat); end
    total++; if (control_out[0] !== 16'd200) begin bad++; $display("FAIL mid_after_out0 got=%0d exp=200", $signed(control_out[0])); end
    total++; if (control_out[1] !== 16'd30) begin bad++; $display("FAIL mid_after_out1 got=%0d exp=30", $signed(control_out[1])); end
    total++; if (sat !== 2'b00) begin bad++; $display("FAIL mid_after_sat got=%b exp=00", sat); end
  endtask

  initial begin
    test_reset();
    test_prop();
    test_sat();
    test_integ();
    test_deriv();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
